uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: TIMEOUT, default 8, is the maximum number of cycles in LAUNCH while waiting for tx_active.
REQ-002 baud_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 arst_n  input  1  synchronous active-low reset, sampled on rising baud_clk.
REQ-004 req  input  4  per-requester frame request, level, bit i = requester i.
REQ-005 data_in  input  32  requester payloads, byte i = data_in[8i+7:8i].
REQ-006 data_length  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-007 stop_bits  input  1  1 = two stop bits, 0 = one.
REQ-008 parity_type  input  2  01 = odd, 10 = even, 00/11 = no parity bit.
REQ-009 tx_active  input  1  serializer frame-in-progress flag.
REQ-010 tx_done  input  1  serializer stop-bit flag.
REQ-011 send  output  1  frame launch to the serializer.
REQ-012 data_out  output  8  latched payload to the serializer.
REQ-013 parity_out  output  1  computed parity bit to the serializer.
REQ-014 length_out, stop_out, parity_type_out  output  1/1/2  latched frame configuration.
REQ-015 ack  output  4  one-cycle completion pulse to the granted requester.
REQ-016 grant_id  output  2  index of the current or last granted requester.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err  output  1  one-cycle pulse on LAUNCH timeout.

Function
REQ-019 FSM states SHALL be IDLE, LAUNCH, BUSY and DONE; all outputs SHALL be registered.
REQ-020 IDLE SHALL transition to LAUNCH on the next edge if any req bit is high.
REQ-021 On that edge the block SHALL latch grant_id, the selected data byte, data_length, stop_bits and parity_type.
REQ-022 Arbitration SHALL be round-robin, searching upward from (ptr+1) mod 4, where ptr is the last granted index.
REQ-023 Requests SHALL be sampled only in IDLE; req changes in other states SHALL be ignored.
REQ-024 Dropping req after grant SHALL NOT abort the frame.
REQ-025 Configuration changes after grant SHALL NOT affect the latched outputs until the next grant.
REQ-026 parity_out SHALL be the XOR of data_out[7:0] when length_out=1, or of data_out[6:0] when length_out=0.
REQ-027 parity_out SHALL additionally be inverted for odd parity (01).
REQ-028 parity_out SHALL be 0 when parity_type_out is 00 or 11.
REQ-029 send SHALL be 1 throughout LAUNCH and 0 in every other state.
REQ-030 LAUNCH SHALL transition to BUSY on the first cycle tx_active=1.
REQ-031 A 4-bit timeout counter SHALL clear on entry to LAUNCH and increment each LAUNCH cycle.
REQ-032 When the counter reaches TIMEOUT with tx_active still 0, the block SHALL pulse err for one cycle, issue no ack, update ptr to grant_id and return to IDLE.
REQ-033 BUSY SHALL transition to DONE on the first cycle tx_done=1.
REQ-034 In BUSY, tx_active falling without tx_done SHALL be treated as completion.
REQ-035 In DONE, ack[grant_id] SHALL be 1 for exactly one cycle, ptr SHALL update to grant_id, and the next state SHALL be IDLE.
REQ-036 The minimum gap between frames SHALL be one IDLE cycle; at most one ack bit SHALL ever be high.
REQ-037 Simultaneous tx_active and tx_done in LAUNCH SHALL transition to BUSY, with completion taken on the following cycle if tx_done persists.

Reset
REQ-038 While arst_n=0 at a rising edge, the block SHALL go to IDLE with ptr=3, grant_id=0 and the counter cleared.
REQ-039 During that reset, send, data_out, parity_out, length_out, stop_out, parity_type_out, ack, busy and err SHALL all be 0.
REQ-040 Reset asserted mid-frame SHALL abandon the frame with no ack and no err.
REQ-041 Reset SHALL have priority over all transitions.

Verification
REQ-042 Single request: req=0001, byte0=0x75, parity=10, len=1 -> grant_id=0, data_out=0x75, parity_out=1, send held until tx_active, ack=0001 one cycle after tx_done.
REQ-043 Contention: req=1111 held through four frames from reset -> grant order 0,1,2,3 with one ack each.
REQ-044 Odd parity, 7 bits: byte=0xF5, parity_type=01, len=0 -> parity_out=0.
REQ-045 Timeout: tx_active tied 0, TIMEOUT=8 -> err pulses after 8 LAUNCH cycles, no ack, and the next grant goes to the next index.
REQ-046 Mid-frame disturbance: change parity_type and drop req during BUSY -> latched outputs unchanged and ack still issued.
REQ-047 Mid-frame reset: arst_n=0 during BUSY -> all outputs 0 next cycle, no ack, then a fresh grant starts from index 0.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Requester/serializer bundle for the UART transmit scheduler.
// The scheduler uses the slave view; whoever drives requests and models the serializer uses master.
interface uart_tx_sched_if;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        data_length;
  logic        stop_bits;
  logic [1:0]  parity_type;
  logic        tx_active;
  logic        tx_done;

  logic        send;
  logic [7:0]  data_out;
  logic        parity_out;
  logic        length_out;
  logic        stop_out;
  logic [1:0]  parity_type_out;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;

  modport slave (
    input  req, data_in, data_length, stop_bits, parity_type, tx_active, tx_done,
    output send, data_out, parity_out, length_out, stop_out, parity_type_out,
           ack, grant_id, busy, err
  );

  modport master (
    output req, data_in, data_length, stop_bits, parity_type, tx_active, tx_done,
    input  send, data_out, parity_out, length_out, stop_out, parity_type_out,
           ack, grant_id, busy, err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler granting one of four requesters a UART frame, latching its payload and
// frame configuration and sequencing launch/completion against an external serializer.
module uart_tx_sched #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic           baud_clk,
  input  logic           arst_n,
  uart_tx_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StDone} state_e;

  localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);

  state_e      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  grant_q;
  logic [3:0]  cnt_q;
  logic        send_q;
  logic [7:0]  data_q;
  logic        par_q;
  logic        len_q;
  logic        stop_q;
  logic [1:0]  ptype_q;
  logic [3:0]  ack_q;
  logic        busy_q;
  logic        err_q;

  logic        pick_vld;
  logic [1:0]  pick_id;
  logic [1:0]  idx;
  logic [7:0]  pick_byte;

  function automatic logic frame_parity(logic [7:0] d, logic len8, logic [1:0] ptype);
    logic x;
    x = len8 ? ^d : ^d[6:0];
    case (ptype)
      2'b01:   return ~x;
      2'b10:   return x;
      default: return 1'b0;
    endcase
  endfunction

  // Search upward from the requester after the last one served; k=4 wraps back to ptr itself.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = ptr_q;
    idx      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  assign pick_byte = bus.data_in[{pick_id, 3'b000} +: 8];

  always_ff @(posedge baud_clk) begin
    if (!arst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd3;
      grant_q <= 2'd0;
      cnt_q   <= 4'd0;
      send_q  <= 1'b0;
      data_q  <= 8'd0;
      par_q   <= 1'b0;
      len_q   <= 1'b0;
      stop_q  <= 1'b0;
      ptype_q <= 2'd0;
      ack_q   <= 4'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 4'd0;
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_vld) begin
            state_q <= StLaunch;
            grant_q <= pick_id;
            data_q  <= pick_byte;
            len_q   <= bus.data_length;
            stop_q  <= bus.stop_bits;
            ptype_q <= bus.parity_type;
            par_q   <= frame_parity(pick_byte, bus.data_length, bus.parity_type);
            cnt_q   <= 4'd0;
            send_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StLaunch: begin
          if (bus.tx_active) begin
            state_q <= StBusy;
            send_q  <= 1'b0;
          end else if (cnt_q == TimeoutLast) begin
            // Serializer never picked the frame up: drop it, but still rotate priority.
            state_q <= StIdle;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            ptr_q   <= grant_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StBusy: begin
          if (bus.tx_done || !bus.tx_active) begin
            state_q <= StDone;
            ack_q   <= 4'b0001 << grant_q;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ptr_q   <= grant_q;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.send            = send_q;
  assign bus.data_out        = data_q;
  assign bus.parity_out      = par_q;
  assign bus.length_out      = len_q;
  assign bus.stop_out        = stop_q;
  assign bus.parity_type_out = ptype_q;
  assign bus.ack             = ack_q;
  assign bus.grant_id        = grant_q;
  assign bus.busy            = busy_q;
  assign bus.err             = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: stimulus pushes expected completions into a scoreboard,
// a negedge monitor pops them whenever ack or err appears.
module tb_uart_tx_sched;

  localparam int TimeoutCyc = 8;

  logic baud_clk = 1'b0;
  logic arst_n;

  uart_tx_sched_if tif();

  uart_tx_sched #(.TIMEOUT(TimeoutCyc)) dut (
    .baud_clk (baud_clk),
    .arst_n   (arst_n),
    .bus      (tif)
  );

  always #5 baud_clk = ~baud_clk;

  typedef struct {
    bit         is_err;
    int         id;
    logic [7:0] data;
    logic       par;
    logic       len;
    logic       stop;
    logic [1:0] ptype;
  } exp_t;

  typedef enum int {MDone, MDrop, MSimul, MTimeout, MReset} mode_e;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_ptr = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: first requester at or after ptr+1 (mod 4).
  function automatic int model_pick(input logic [3:0] mask, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      if (mask[2'((ptr + k) % 4)]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Reference: parity bit chosen so the count of ones (data + parity) is even or odd.
  function automatic logic model_parity(input logic [7:0] d, input logic len8,
                                        input logic [1:0] pt);
    int ones = 0;
    int nbits = len8 ? 8 : 7;
    for (int i = 0; i < nbits; i++) if (d[i]) ones++;
    if (pt == 2'b10) return 1'(ones % 2);
    if (pt == 2'b01) return 1'((ones + 1) % 2);
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_send"},   32'(tif.send), 0);
    check({tag, "_data"},   32'(tif.data_out), 0);
    check({tag, "_par"},    32'(tif.parity_out), 0);
    check({tag, "_len"},    32'(tif.length_out), 0);
    check({tag, "_stop"},   32'(tif.stop_out), 0);
    check({tag, "_ptype"},  32'(tif.parity_type_out), 0);
    check({tag, "_ack"},    32'(tif.ack), 0);
    check({tag, "_busy"},   32'(tif.busy), 0);
    check({tag, "_err"},    32'(tif.err), 0);
    check({tag, "_grant"},  32'(tif.grant_id), 0);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    tick();
    tick();
    check_zero("reset");
    arst_n    = 1'b1;
    model_ptr = 3;
    sb.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (tif.busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check({name, "_idle"}, 32'(tif.busy), 0);
  endtask

  // Entered at #1 into an IDLE cycle; returns at #1 into the next IDLE cycle.
  task automatic frame(input logic [3:0] mask, input logic [31:0] bytes, input logic len8,
                       input logic stop2, input logic [1:0] pt, input mode_e mode,
                       input int lat, input int blen, input bit disturb);
    int   id;
    int   cnt;
    exp_t e;
    id = model_pick(mask, model_ptr);
    tif.req         = mask;
    tif.data_in     = bytes;
    tif.data_length = len8;
    tif.stop_bits   = stop2;
    tif.parity_type = pt;
    e.is_err = (mode == MTimeout);
    e.id     = id;
    e.data   = 8'(bytes >> (8 * id));
    e.par    = model_parity(e.data, len8, pt);
    e.len    = len8;
    e.stop   = stop2;
    e.ptype  = pt;
    if (mode != MReset) begin
      sb.push_back(e);
      model_ptr = id;
    end
    tick();
    check("send_on_grant", 32'(tif.send), 1);
    check("grant_id_live", 32'(tif.grant_id), 32'(id));
    if (disturb) begin
      tif.req         = 4'($urandom);
      tif.data_in     = $urandom;
      tif.data_length = 1'($urandom);
      tif.stop_bits   = 1'($urandom);
      tif.parity_type = 2'($urandom);
    end
    if (mode == MTimeout) begin
      cnt = 0;
      while (tif.send === 1'b1 && cnt < 3 * TimeoutCyc) begin
        cnt++;
        tick();
      end
      check("launch_cycles", 32'(cnt), 32'(TimeoutCyc));
      check("idle_after_timeout", 32'(tif.busy), 0);
      return;
    end
    for (int c = 0; c < lat; c++) begin
      check("send_held", 32'(tif.send), 1);
      tick();
    end
    check("send_held", 32'(tif.send), 1);
    tif.tx_active = 1'b1;
    tif.tx_done   = (mode == MSimul);
    tick();
    check("send_drop", 32'(tif.send), 0);
    check("busy_high", 32'(tif.busy), 1);
    if (mode == MReset) begin
      arst_n = 1'b0;
      tick();
      check_zero("midreset");
      arst_n        = 1'b1;
      tif.tx_active = 1'b0;
      tif.tx_done   = 1'b0;
      model_ptr     = 3;
      return;
    end
    if (mode != MSimul) begin
      repeat (blen) begin
        check("ack_early", 32'(tif.ack), 0);
        tick();
      end
      if (mode == MDone) tif.tx_done = 1'b1;
      else tif.tx_active = 1'b0;
    end
    tick();
    check("ack_timing", 32'(tif.ack), 32'(1 << id));
    tif.tx_active = 1'b0;
    tif.tx_done   = 1'b0;
    wait_idle("frame_end");
  endtask

  // Monitor: every ack/err cycle must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge baud_clk);
      if (tif.ack !== 4'd0 || tif.err !== 1'b0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: ack=%b err=%b, required none (t=%0t)",
                   tif.ack, tif.err, $time);
        end else begin
          e = sb.pop_front();
          check("mon_err",   32'(tif.err), 32'(e.is_err));
          check("mon_ack",   32'(tif.ack), e.is_err ? 32'd0 : 32'(1 << e.id));
          check("mon_grant", 32'(tif.grant_id), 32'(e.id));
          check("mon_data",  32'(tif.data_out), 32'(e.data));
          check("mon_par",   32'(tif.parity_out), 32'(e.par));
          check("mon_len",   32'(tif.length_out), 32'(e.len));
          check("mon_stop",  32'(tif.stop_out), 32'(e.stop));
          check("mon_ptype", 32'(tif.parity_type_out), 32'(e.ptype));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mode_e m;
    int    r;
    arst_n          = 1'b0;
    tif.req         = 4'd0;
    tif.data_in     = 32'd0;
    tif.data_length = 1'b0;
    tif.stop_bits   = 1'b0;
    tif.parity_type = 2'd0;
    tif.tx_active   = 1'b0;
    tif.tx_done     = 1'b0;
    tick();
    do_reset();

    // Single request, even parity on 0x75.
    frame(4'b0001, 32'h0000_0075, 1'b1, 1'b0, 2'b10, MDone, 2, 1, 1'b0);

    // Four-way contention from reset.
    do_reset();
    for (int i = 0; i < 4; i++) frame(4'b1111, 32'hA1B2_C3D4, 1'b1, 1'b1, 2'b01, MDone, 1, 2, 1'b0);

    // Odd parity over 7 bits of 0xF5.
    frame(4'b0100, 32'h00F5_0000, 1'b0, 1'b0, 2'b01, MDrop, 0, 0, 1'b0);

    // Launch timeout, then priority moves past the timed-out requester.
    frame(4'b0010, 32'h1234_5678, 1'b1, 1'b0, 2'b00, MTimeout, 0, 0, 1'b0);
    frame(4'b1111, 32'h1234_5678, 1'b1, 1'b0, 2'b11, MDone, TimeoutCyc - 1, 0, 1'b0);

    // Disturbance while busy, simultaneous active/done, then mid-frame reset.
    frame(4'b1000, 32'h5A00_0000, 1'b1, 1'b1, 2'b10, MDone, 3, 3, 1'b1);
    frame(4'b0011, 32'h0000_80FF, 1'b0, 1'b1, 2'b10, MSimul, 0, 0, 1'b1);
    frame(4'b0110, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b01, MReset, 1, 0, 1'b1);
    frame(4'b1111, 32'hCAFE_F00D, 1'b1, 1'b0, 2'b10, MDone, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      m = MDone;
      else if (r <= 5) m = MDrop;
      else if (r <= 7) m = MSimul;
      else if (r == 8) m = MTimeout;
      else             m = MReset;
      frame(4'($urandom_range(1, 15)), $urandom, 1'($urandom), 1'($urandom), 2'($urandom), m,
            $urandom_range(0, TimeoutCyc - 1), $urandom_range(0, 3), 1'($urandom));
    end

    tif.req = 4'd0;
    repeat (5) tick();
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
